// File: rtl/hex_field_writer.sv
// Prints a 4*DIGITS-bit value as DIGITS hex characters into the text buffer, one per clock.
// Latency: first write is registered one cycle after the accepting start edge; one field per DIGITS+1 cycles.
// No backpressure: start is sampled only in IDLE and dropped (not queued) while busy.
module hex_field_writer #(
    parameter int DIGITS = 4,
    parameter int COLS   = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [4:0]            row,
    input  logic [6:0]            col,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic [11:0]           rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  txt_we,
    output logic [11:0]           txt_addr,
    output logic [7:0]            txt_data
);

    localparam int         VW     = 4 * DIGITS;
    localparam logic [3:0] LAST_K = 4'(DIGITS - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t         state_q, state_d;
    logic [VW-1:0]  sr_q, sr_d;
    logic [3:0]     k_q, k_d;
    logic           lz_q, lz_d;
    logic           blank_q, blank_d;
    logic [11:0]    base_q, base_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           txt_we_q, txt_we_d;
    logic [11:0]    txt_addr_q, txt_addr_d;
    logic [7:0]     txt_data_q, txt_data_d;

    logic [3:0]     nib;
    logic [11:0]    lin_addr;

    // Next-state logic: accept a field in IDLE, then emit one character per cycle in EMIT.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        k_d        = k_q;
        lz_d       = lz_q;
        blank_d    = blank_q;
        base_d     = base_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        txt_we_d   = 1'b0;
        txt_addr_d = txt_addr_q;
        txt_data_d = txt_data_q;
        rom_addr   = 12'h000;
        nib        = sr_q[VW-1 -: 4];
        // Only the low 12 bits of row*COLS+col are kept, so modulo-4096
        // arithmetic gives the same address as a wider product truncated.
        lin_addr   = 12'(row) * 12'(COLS) + 12'(col);

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = value;
                    blank_d = blank_lz;
                    base_d  = lin_addr;
                    k_d     = 4'd0;
                    lz_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                rom_addr   = {8'h00, nib};
                txt_we_d   = 1'b1;
                txt_addr_d = base_q + {8'h00, k_q};
                // The last digit is never blanked so zero still shows as '0'.
                if (blank_q && lz_q && (nib == 4'h0) && (k_q != LAST_K)) begin
                    txt_data_d = 8'd32;
                end else begin
                    txt_data_d = rom_data;
                    lz_d       = 1'b0;
                end
                sr_d = sr_q << 4;
                k_d  = k_q + 4'd1;
                if (k_q == LAST_K) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any field in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            k_q        <= 4'd0;
            lz_q       <= 1'b0;
            blank_q    <= 1'b0;
            base_q     <= 12'h000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            txt_we_q   <= 1'b0;
            txt_addr_q <= 12'h000;
            txt_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            k_q        <= k_d;
            lz_q       <= lz_d;
            blank_q    <= blank_d;
            base_q     <= base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            txt_we_q   <= txt_we_d;
            txt_addr_q <= txt_addr_d;
            txt_data_q <= txt_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign txt_we   = txt_we_q;
    assign txt_addr = txt_addr_q;
    assign txt_data = txt_data_q;

endmodule

// File: tb/tb_hex_field_writer.sv
// Directed bench for hex_field_writer: two instances (COLS=80 and COLS=128) share stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
// Each instance drives its own behavioural hex-digit ROM.
module tb_hex_field_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] value;
    logic [4:0]  row;
    logic [6:0]  col;
    logic        blank_lz;

    logic        busy, done, txt_we;
    logic [11:0] rom_addr, txt_addr;
    logic [7:0]  rom_data, txt_data;

    logic        busy_w, done_w, txt_we_w;
    logic [11:0] rom_addr_w, txt_addr_w;
    logic [7:0]  rom_data_w, txt_data_w;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'd48 + {4'd0, n}) : (8'd55 + {4'd0, n});
    endfunction

    assign rom_data   = hex_ascii(rom_addr[3:0]);
    assign rom_data_w = hex_ascii(rom_addr_w[3:0]);

    hex_field_writer #(.DIGITS(4), .COLS(80)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .row(row), .col(col),
        .blank_lz(blank_lz), .busy(busy), .done(done), .rom_addr(rom_addr),
        .rom_data(rom_data), .txt_we(txt_we), .txt_addr(txt_addr), .txt_data(txt_data)
    );

    hex_field_writer #(.DIGITS(4), .COLS(128)) dut_w (
        .clk(clk), .rst(rst), .start(start), .value(value), .row(row), .col(col),
        .blank_lz(blank_lz), .busy(busy_w), .done(done_w), .rom_addr(rom_addr_w),
        .rom_data(rom_data_w), .txt_we(txt_we_w), .txt_addr(txt_addr_w), .txt_data(txt_data_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One full field: addrs/datas hold the four expected writes, MSD first.
    task automatic run_field(input string name, input logic [15:0] v, input logic [4:0] r,
                             input logic [6:0] c, input logic blz, input logic use_w,
                             input logic [47:0] addrs, input logic [31:0] datas);
        logic [11:0] o_addr;
        logic [7:0]  o_data;
        logic        o_we, o_done, o_busy;
        logic [11:0] o_rom;
        @(negedge clk);
        start = 1'b1; value = v; row = r; col = c; blank_lz = blz;
        @(negedge clk);
        // Inputs scrambled after acceptance; the field must use latched values.
        start = 1'b0; value = ~v; row = ~r; col = ~c; blank_lz = ~blz;
        o_busy = use_w ? busy_w : busy;
        o_we   = use_w ? txt_we_w : txt_we;
        o_rom  = use_w ? rom_addr_w : rom_addr;
        chk({name, " busy0"}, {31'd0, o_busy}, 32'd1);
        chk({name, " we0"},   {31'd0, o_we},   32'd0);
        chk({name, " rom0"},  {20'd0, o_rom},  {28'd0, v[15:12]});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            o_we   = use_w ? txt_we_w : txt_we;
            o_addr = use_w ? txt_addr_w : txt_addr;
            o_data = use_w ? txt_data_w : txt_data;
            o_done = use_w ? done_w : done;
            o_busy = use_w ? busy_w : busy;
            o_rom  = use_w ? rom_addr_w : rom_addr;
            chk($sformatf("%s we%0d", name, k),   {31'd0, o_we},   32'd1);
            chk($sformatf("%s addr%0d", name, k), {20'd0, o_addr}, {20'd0, addrs[47-12*k -: 12]});
            chk($sformatf("%s data%0d", name, k), {24'd0, o_data}, {24'd0, datas[31-8*k -: 8]});
            chk($sformatf("%s done%0d", name, k), {31'd0, o_done}, (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s busy%0d", name, k), {31'd0, o_busy}, (k == 3) ? 32'd0 : 32'd1);
            chk($sformatf("%s rom%0d", name, k+1), {20'd0, o_rom},
                (k == 3) ? 32'd0 : {28'd0, v[11-4*k -: 4]});
        end
        @(negedge clk);
        o_we   = use_w ? txt_we_w : txt_we;
        o_done = use_w ? done_w : done;
        chk({name, " we_after"},   {31'd0, o_we},   32'd0);
        chk({name, " done_after"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; value = 16'h0; row = 5'd0; col = 7'd0; blank_lz = 1'b0;
        #2;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst we",   {31'd0, txt_we}, 32'd0);
        chk("rst addr", {20'd0, txt_addr}, 32'd0);
        chk("rst data", {24'd0, txt_data}, 32'd0);
        chk("rst rom",  {20'd0, rom_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle rom", {20'd0, rom_addr}, 32'd0);

        // Basic: row 2, col 10 -> base 170; '3','A','0','F'.
        run_field("f3A0F", 16'h3A0F, 5'd2, 7'd10, 1'b0, 1'b0,
                  {12'd170, 12'd171, 12'd172, 12'd173}, {8'd51, 8'd65, 8'd48, 8'd70});
        // Leading-zero blanking.
        run_field("b000F", 16'h000F, 5'd0, 7'd0, 1'b1, 1'b0,
                  {12'd0, 12'd1, 12'd2, 12'd3}, {8'd32, 8'd32, 8'd32, 8'd70});
        run_field("b0000", 16'h0000, 5'd0, 7'd0, 1'b1, 1'b0,
                  {12'd0, 12'd1, 12'd2, 12'd3}, {8'd32, 8'd32, 8'd32, 8'd48});
        run_field("b0100", 16'h0100, 5'd0, 7'd0, 1'b1, 1'b0,
                  {12'd0, 12'd1, 12'd2, 12'd3}, {8'd32, 8'd49, 8'd48, 8'd48});
        // Blanking on with nonzero MSD: interior zero is printed. 3*80+79 = 319.
        run_field("b3A0F", 16'h3A0F, 5'd3, 7'd79, 1'b1, 1'b0,
                  {12'd319, 12'd320, 12'd321, 12'd322}, {8'd51, 8'd65, 8'd48, 8'd70});
        // Address wrap on the COLS=128 instance: 31*128+127 = 4095.
        run_field("wrap", 16'h1234, 5'd31, 7'd127, 1'b0, 1'b1,
                  {12'd4095, 12'd0, 12'd1, 12'd2}, {8'd49, 8'd50, 8'd51, 8'd52});
        // ROM nibble sequence B,E,E,F at row 1 -> base 80.
        run_field("BEEF", 16'hBEEF, 5'd1, 7'd0, 1'b0, 1'b0,
                  {12'd80, 12'd81, 12'd82, 12'd83}, {8'd66, 8'd69, 8'd69, 8'd70});

        // start held high: second field accepted at E5, writes after E1..E4 and E6..E9.
        @(negedge clk);
        start = 1'b1; value = 16'hFFFF; row = 5'd0; col = 7'd0; blank_lz = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) value = 16'h0000;
            if (i == 5) start = 1'b0;
            chk($sformatf("b2b we%0d", i), {31'd0, txt_we},
                ((i >= 1 && i <= 4) || (i >= 6 && i <= 9)) ? 32'd1 : 32'd0);
            chk($sformatf("b2b done%0d", i), {31'd0, done}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
            chk($sformatf("b2b busy%0d", i), {31'd0, busy},
                ((i <= 3) || (i >= 5 && i <= 8)) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 4) begin
                chk($sformatf("b2b addr%0d", i), {20'd0, txt_addr}, i - 1);
                chk($sformatf("b2b data%0d", i), {24'd0, txt_data}, 32'd70);
            end
            if (i >= 6 && i <= 9) begin
                chk($sformatf("b2b addr%0d", i), {20'd0, txt_addr}, i - 6);
                chk($sformatf("b2b data%0d", i), {24'd0, txt_data}, 32'd48);
            end
        end

        // Reset after the second write of a field.
        @(negedge clk);
        start = 1'b1; value = 16'h3A0F; row = 5'd2; col = 7'd10; blank_lz = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid we2",   {31'd0, txt_we}, 32'd1);
        chk("mid data2", {24'd0, txt_data}, 32'd65);
        #1 rst = 1'b1;
        #1;
        chk("arst we",   {31'd0, txt_we}, 32'd0);
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst done", {31'd0, done}, 32'd0);
        chk("arst addr", {20'd0, txt_addr}, 32'd0);
        chk("arst rom",  {20'd0, rom_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst we%0d", i),   {31'd0, txt_we}, 32'd0);
            chk($sformatf("post-rst busy%0d", i), {31'd0, busy}, 32'd0);
        end
        run_field("after_rst", 16'h3A0F, 5'd2, 7'd10, 1'b0, 1'b0,
                  {12'd170, 12'd171, 12'd172, 12'd173}, {8'd51, 8'd65, 8'd48, 8'd70});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
